// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX write port among N_REQ requesters.
// Each granted packet is shadowed, then pushed as a source header plus payload bytes.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned PKT_BYTES = 4,
  parameter logic [7:0]  HDR_BASE  = 8'hA0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*PKT_BYTES*8-1:0] pkt_data,
  input  logic                         tx_full,
  output logic                         wr_uart,
  output logic [7:0]                   w_data,
  output logic [N_REQ-1:0]             grant,
  output logic [N_REQ-1:0]             done,
  output logic                         busy
);

  localparam int unsigned PKT_W = PKT_BYTES * 8;
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;

  state_t           state;
  logic [PKT_W-1:0] shadow;
  logic [ID_W-1:0]  last_grant;
  logic [IDX_W-1:0] idx;

  logic [ID_W-1:0]  pick;
  logic             pick_valid;
  logic [ID_W:0]    cand;
  logic [PKT_W-1:0] pick_pkt;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] idx_nxt;
  logic [7:0]       next_byte;

  // Search starts one past the previous owner and wraps modulo N_REQ.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!pick_valid && req[cand[ID_W-1:0]]) begin
        pick       = cand[ID_W-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    pick_pkt    = '0;
    pick_onehot = '0;
    pick_onehot[pick] = 1'b1;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick == ID_W'(i)) pick_pkt = pkt_data[i*PKT_W +: PKT_W];
    end
  end

  always_comb begin
    idx_nxt   = idx + IDX_W'(1);
    next_byte = '0;
    for (int unsigned i = 0; i < PKT_BYTES; i++) begin
      if (idx_nxt == IDX_W'(i)) next_byte = shadow[i*8 +: 8];
    end
  end

  assign wr_uart = ((state == HEADER) || (state == PAYLOAD)) && !tx_full;
  assign busy    = (state != IDLE);

  // w_data is preloaded with the next byte on every push, so it stays stable under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shadow     <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      idx        <= '0;
      grant      <= '0;
      done       <= '0;
      w_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            shadow     <= pick_pkt;
            grant      <= pick_onehot;
            last_grant <= pick;
            w_data     <= HDR_BASE | 8'(pick);
            state      <= HEADER;
          end
        end
        HEADER: begin
          if (!tx_full) begin
            idx    <= '0;
            w_data <= shadow[7:0];
            state  <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!tx_full) begin
            if (idx == IDX_W'(PKT_BYTES - 1)) begin
              done  <= grant;
              state <= DONE;
            end else begin
              idx    <= idx_nxt;
              w_data <= next_byte;
            end
          end
        end
        DONE: begin
          done  <= '0;
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scenario bench for uart_tx_arbiter: directed cases plus a randomized run
// against a packet-level round-robin/byte-queue reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int PB = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*PB*8-1:0] pkt_data = '0;
  logic             tx_full = 1'b0;
  logic             wr_uart;
  logic [7:0]       w_data;
  logic [N-1:0]     grant;
  logic [N-1:0]     done;
  logic             busy;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(
    .N_REQ(N),
    .PKT_BYTES(PB),
    .HDR_BASE(8'hA0)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .pkt_data(pkt_data), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .grant(grant), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic full);
    reset   = 1'b0;
    req     = '0;
    tx_full = full;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [7:0] slice_byte(input logic [N*PB*8-1:0] d, input int r, input int b);
    return d[(r*PB+b)*8 +: 8];
  endfunction

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    total++; if (wr_uart !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", wr_uart); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
    total++; if (done !== 2'b00) begin bad++; $display("FAIL reset_done got=%b exp=00", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (w_data !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", w_data); end
  endtask

  task automatic test_single();
    logic [7:0] e [5];
    e = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset(1'b0);
    pkt_data = '0;
    pkt_data[31:0] = 32'h44332211;
    req = 2'b01;
    next();
    req = 2'b00;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (wr_uart !== 1'b1) begin bad++; $display("FAIL single_wr k=%0d got=%b exp=1", k, wr_uart); end
      total++; if (w_data !== e[k]) begin bad++; $display("FAIL single_data k=%0d got=%h exp=%h", k, w_data, e[k]); end
      total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant k=%0d got=%b exp=01", k, grant); end
      next();
    end
    #1;
    total++; if (done !== 2'b01) begin bad++; $display("FAIL single_done got=%b exp=01", done); end
    total++; if (wr_uart !== 1'b0) begin bad++; $display("FAIL single_done_wr got=%b exp=0", wr_uart); end
    next();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_idle_grant got=%b exp=00", grant); end
    total++; if (done !== 2'b00) begin bad++; $display("FAIL single_idle_done got=%b exp=00", done); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] pk [N][PB];
    int id;
    do_reset(1'b0);
    for (int r = 0; r < N; r++)
      for (int b = 0; b < PB; b++) begin
        pk[r][b] = 8'($urandom);
        pkt_data[(r*PB+b)*8 +: 8] = pk[r][b];
      end
    req = 2'b11;
    next();
    for (int p = 0; p < 4; p++) begin
      id = p % 2;
      #1;
      total++; if (!(wr_uart === 1'b1 && w_data === (8'hA0 | 8'(id))))
        begin bad++; $display("FAIL rr_header p=%0d got=%b/%h exp=1/%h", p, wr_uart, w_data, 8'hA0 | 8'(id)); end
      next();
      for (int b = 0; b < PB; b++) begin
        #1;
        total++; if (!(wr_uart === 1'b1 && w_data === pk[id][b]))
          begin bad++; $display("FAIL rr_byte p=%0d b=%0d got=%b/%h exp=1/%h", p, b, wr_uart, w_data, pk[id][b]); end
        next();
      end
      #1;
      total++; if (done !== (2'b01 << id)) begin bad++; $display("FAIL rr_done p=%0d got=%b exp=%b", p, done, 2'b01 << id); end
      next();
      if (p == 3) req = 2'b00;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_gap p=%0d busy got=%b exp=0", p, busy); end
      next();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e [5];
    int pushes;
    int pi;
    e = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h44};
    pushes = 0;
    pi = 0;
    do_reset(1'b0);
    pkt_data = '0;
    pkt_data[31:0] = 32'h44332211;
    req = 2'b01;
    next();
    req = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      tx_full = (c >= 3 && c <= 5);
      #1;
      if (tx_full) begin
        total++; if (!(wr_uart === 1'b0 && w_data === 8'h22))
          begin bad++; $display("FAIL bp_stall c=%0d got=%b/%h exp=0/22", c, wr_uart, w_data); end
      end
      if (wr_uart === 1'b1) begin
        total++; if (pi > 4 || w_data !== e[pi > 4 ? 4 : pi])
          begin bad++; $display("FAIL bp_byte c=%0d got=%h exp=%h", c, w_data, e[pi > 4 ? 4 : pi]); end
        pi++;
        pushes++;
      end
      total++; if (done !== ((c == 9) ? 2'b01 : 2'b00))
        begin bad++; $display("FAIL bp_done c=%0d got=%b exp=%b", c, done, (c == 9) ? 2'b01 : 2'b00); end
      next();
    end
    tx_full = 1'b0;
    total++; if (pushes != 5) begin bad++; $display("FAIL bp_pushes got=%0d exp=5", pushes); end
  endtask

  task automatic test_withdraw();
    logic [7:0] orig [PB];
    do_reset(1'b0);
    pkt_data = {$urandom, $urandom};
    for (int b = 0; b < PB; b++) orig[b] = slice_byte(pkt_data, 1, b);
    req = 2'b10;
    next();
    req = 2'b00;
    #1;
    total++; if (!(wr_uart === 1'b1 && w_data === 8'hA1))
      begin bad++; $display("FAIL wd_header got=%b/%h exp=1/a1", wr_uart, w_data); end
    pkt_data[PB*8 +: PB*8] = ~pkt_data[PB*8 +: PB*8];
    next();
    for (int b = 0; b < PB; b++) begin
      #1;
      total++; if (!(wr_uart === 1'b1 && w_data === orig[b]))
        begin bad++; $display("FAIL wd_byte b=%0d got=%b/%h exp=1/%h", b, wr_uart, w_data, orig[b]); end
      next();
    end
    #1;
    total++; if (done !== 2'b10) begin bad++; $display("FAIL wd_done got=%b exp=10", done); end
    next();
    next();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wd_no_rearb busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s1 [PB];
    do_reset(1'b0);
    pkt_data = {$urandom, $urandom};
    req = 2'b01;
    next();
    req = 2'b00;
    repeat (3) next();
    #2 reset = 1'b0;
    #1;
    total++; if (!(wr_uart === 1'b0 && grant === 2'b00 && busy === 1'b0 && done === 2'b00))
      begin bad++; $display("FAIL rm_async got=%b/%b/%b/%b exp=0/00/0/00", wr_uart, grant, busy, done); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    pkt_data = {$urandom, $urandom};
    for (int b = 0; b < PB; b++) s1[b] = slice_byte(pkt_data, 1, b);
    req = 2'b10;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_release_busy got=%b exp=0", busy); end
    next();
    req = 2'b00;
    #1;
    total++; if (!(wr_uart === 1'b1 && w_data === 8'hA1 && grant === 2'b10))
      begin bad++; $display("FAIL rm_header got=%b/%h/%b exp=1/a1/10", wr_uart, w_data, grant); end
    next();
    for (int b = 0; b < PB; b++) begin
      #1;
      total++; if (!(wr_uart === 1'b1 && w_data === s1[b]))
        begin bad++; $display("FAIL rm_byte b=%0d got=%b/%h exp=1/%h", b, wr_uart, w_data, s1[b]); end
      next();
    end
    #1;
    total++; if (done !== 2'b10) begin bad++; $display("FAIL rm_done got=%b exp=10", done); end
    next();
  endtask

  task automatic test_full_at_reset();
    do_reset(1'b1);
    req = 2'b01;
    next();
    req = 2'b00;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (!(busy === 1'b1 && wr_uart === 1'b0 && w_data === 8'hA0))
        begin bad++; $display("FAIL fr_wait c=%0d got=%b/%b/%h exp=1/0/a0", c, busy, wr_uart, w_data); end
      next();
    end
    tx_full = 1'b0;
    #1;
    total++; if (!(wr_uart === 1'b1 && w_data === 8'hA0))
      begin bad++; $display("FAIL fr_first_push got=%b/%h exp=1/a0", wr_uart, w_data); end
    repeat (7) next();
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    int m_last;
    int m_id;
    int done_due;
    int c;
    do_reset(1'b0);
    m_last = N - 1;
    m_id = 0;
    done_due = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      req      = N'($urandom_range(0, 3));
      tx_full  = ($urandom_range(0, 9) < 3);
      pkt_data = {$urandom, $urandom};
      #1;
      if (q.size() > 0) begin
        total++; if (!(busy === 1'b1 && grant === N'(1 << m_id) && wr_uart === !tx_full && w_data === q[0] && done === '0))
          begin bad++; $display("FAIL rnd_xfer cyc=%0d got=%b/%b/%b/%h/%b exp=1/%b/%b/%h/00",
                                cyc, busy, grant, wr_uart, w_data, done, N'(1 << m_id), !tx_full, q[0]); end
        if (!tx_full) begin
          void'(q.pop_front());
          if (q.size() == 0) done_due = 1;
        end
      end else if (done_due != 0) begin
        total++; if (!(done === N'(1 << m_id) && wr_uart === 1'b0 && busy === 1'b1 && grant === N'(1 << m_id)))
          begin bad++; $display("FAIL rnd_done cyc=%0d got=%b/%b/%b/%b exp=%b/0/1/%b",
                                cyc, done, wr_uart, busy, grant, N'(1 << m_id), N'(1 << m_id)); end
        done_due = 0;
      end else begin
        total++; if (!(busy === 1'b0 && wr_uart === 1'b0 && done === '0 && grant === '0))
          begin bad++; $display("FAIL rnd_idle cyc=%0d got=%b/%b/%b/%b exp=0/0/00/00", cyc, busy, wr_uart, done, grant); end
        if (req != '0) begin
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (req[c]) begin
              m_id = c;
              break;
            end
          end
          m_last = m_id;
          q.push_back(8'hA0 | 8'(m_id));
          for (int b = 0; b < PB; b++) q.push_back(slice_byte(pkt_data, m_id, b));
        end
      end
      next();
    end
    req = '0;
    tx_full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_withdraw();
    test_reset_mid();
    test_full_at_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin packet arbiter that shares the single UART transmit write port (wr_uart / w_data / tx_full) among N_REQ game-side requesters, e.g. snake position and score updates. Each granted requester's packet is latched into a shadow register. The packet is then serialized byte by byte into the UART TX FIFO, prefixed with a header byte that identifies the source. Sits between game logic and the uart unit.

Parameters:
N_REQ, 2, number of requesters (2..8)
PKT_BYTES, 4, payload bytes per packet (1..16)
HDR_BASE, 8'hA0, header byte base; header = HDR_BASE | requester index

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req  input  N_REQ  per-requester packet request, level
pkt_data  input  N_REQ*PKT_BYTES*8  flat packets; requester i occupies slice [i*PKT_BYTES*8 +: PKT_BYTES*8], byte 0 in LSBs
tx_full  input  1  UART TX FIFO full
wr_uart  output  1  one-cycle FIFO push strobe
w_data  output  8  byte to push
grant  output  N_REQ  one-hot, owner of current packet
done  output  N_REQ  one-cycle pulse when owner's packet is fully pushed
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clock, clk. reset is asynchronous and active-low. While reset=0: state=IDLE, grant=0, done=0, busy=0, wr_uart=0, w_data=0, byte index=0, last_grant=N_REQ-1 (requester 0 wins first arbitration). Reset mid-packet aborts the packet; no partial resume.
- FSM states: IDLE, HEADER, PAYLOAD, DONE.
- IDLE:
  - req sampled only in this state.
  - If any req bit is set, pick the first set bit searching from last_grant+1, wrapping modulo N_REQ.
  - Latch that requester's pkt_data slice into the shadow register; set grant one-hot; store the id; update last_grant; go to HEADER.
  - If req=0, stay in IDLE.
- HEADER:
  - wr_uart = ~tx_full (combinational from state).
  - w_data = HDR_BASE | id.
  - On an edge with wr_uart=1, go to PAYLOAD with idx=0. Otherwise hold.
- PAYLOAD:
  - wr_uart = ~tx_full; w_data = shadow byte idx.
  - On a push: if idx==PKT_BYTES-1, go to DONE; else idx++.
  - Byte order: byte 0 first.
- DONE:
  - done[id]=1 for exactly this cycle; grant cleared at the following edge; go to IDLE.
  - wr_uart=0.
- wr_uart is never asserted while tx_full=1, and never outside HEADER/PAYLOAD.
- Exactly PKT_BYTES+1 pushes per packet.
- Latency with no backpressure: req sampled at edge E0 → header pushed in cycle after E0 → payload bytes in the following PKT_BYTES cycles → done pulse in cycle PKT_BYTES+2 after E0 → IDLE one cycle later.
- Minimum gap: one IDLE cycle between consecutive packets.
- Backpressure: tx_full may assert or deassert on any cycle. The FSM stalls in place and keeps w_data stable; no byte is dropped or duplicated.
- After grant:
  - req deassert: ignored, packet committed.
  - pkt_data changes: do not affect the packet in flight (shadow copy).
- Requester holding req high after done is re-arbitrated. Round-robin guarantees every active requester a packet within N_REQ packets.
- Simultaneous reqs at the same sample edge: lowest index after last_grant wins; others wait.
- w_data holds its last value in IDLE/DONE (don't-care to the FIFO).
- busy=1 in HEADER, PAYLOAD and DONE.
- Index arithmetic is modulo N_REQ.
- idx width is clog2(PKT_BYTES), minimum 1 bit.

Test Plan:
- Single request, N_REQ=2, PKT_BYTES=4, tx_full=0:
  - Stimulus: req=01, pkt_data[31:0]=32'h44332211.
  - Required: wr_uart high 5 consecutive cycles with w_data A0,11,22,33,44; done=01 pulse on the 6th cycle after the sample edge; grant=01 throughout; busy low after.
- Simultaneous requests:
  - Stimulus: req=11 held, right after reset.
  - Required: packets alternate with headers A0, A1, A0, A1. Each packet's done pulses the matching bit. One IDLE cycle between packets.
- Backpressure:
  - Stimulus: tx_full=1 for 3 cycles during payload byte 1 (22).
  - Required: wr_uart=0 and w_data=22 stable for those cycles. Stream resumes 22,33,44, still exactly 5 pushes; done is delayed by 3 cycles.
- Withdrawal and data change:
  - Stimulus: req[1] pulses one cycle, then pkt_data slice 1 is changed during HEADER.
  - Required: header A1 followed by the originally latched bytes; done=10.
- Reset mid-packet:
  - Stimulus: reset=0 asserted asynchronously after 2 payload bytes.
  - Required: wr_uart, grant, busy and done drop to 0 immediately. After release with req=10, the first packet starts with header A1; the abandoned packet does not continue and is not completed.
- tx_full held at reset:
  - Stimulus: tx_full=1 at release with req=01.
  - Required: FSM waits in HEADER with busy=1 and no push; first push happens in the cycle tx_full falls.
